// File: rtl/joltage_pkg.sv
// Shared types and constants for the joltage line loader: FSM encoding and
// the ASCII codes the byte classifier recognises.
package joltage_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } loader_state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int DIGIT_W = 4;

endpackage

// File: rtl/joltage_char_class.sv
// Combinational byte classifier: flags decimal digits, LF and CR and yields
// the binary value of a digit character (zero for anything else).
module joltage_char_class
  import joltage_pkg::*;
(
  input  logic [7:0]         data_i,
  output logic               is_digit_o,
  output logic               is_lf_o,
  output logic               is_cr_o,
  output logic [DIGIT_W-1:0] digit_o
);

  assign is_digit_o = (data_i >= ASCII_0) && (data_i <= ASCII_9);
  assign is_lf_o    = (data_i == ASCII_LF);
  assign is_cr_o    = (data_i == ASCII_CR);

  // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
  assign digit_o = is_digit_o ? data_i[DIGIT_W-1:0] : '0;

endmodule

// File: rtl/joltage_line_loader.sv
// Streams ASCII lines of LENGTH digits into a joltage instance one line at a
// time, then snapshots the joltage running totals once the input ends.
module joltage_line_loader
  import joltage_pkg::*;
#(
  parameter int LENGTH = 100,
  parameter int CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       in_data_i,
  input  logic                             in_valid_i,
  input  logic                             in_last_i,
  output logic                             in_ready_o,
  output logic [0:LENGTH-1][DIGIT_W-1:0]   line_o,
  output logic                             start_o,
  output logic                             data_valid_o,
  input  logic                             done_i,
  input  logic [15:0]                      joltage1_i,
  input  logic [63:0]                      joltage2_i,
  output logic [15:0]                      p1_total_o,
  output logic [63:0]                      p2_total_o,
  output logic [CNT_W-1:0]                 lines_done_o,
  output logic                             finished_o,
  output logic                             err_char_o,
  output logic                             err_len_o
);

  localparam int CW = $clog2(LENGTH + 2);
  localparam logic [CW-1:0] LEN_C = CW'(LENGTH);
  localparam logic [CW-1:0] OVF_C = CW'(LENGTH + 1);

  loader_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] lines_done_q, lines_done_d;
  logic [15:0]      p1_q, p1_d;
  logic [63:0]      p2_q, p2_d;
  logic             finished_q, finished_d;
  logic             err_char_q, err_char_d;
  logic             err_len_q, err_len_d;
  logic [0:LENGTH-1][DIGIT_W-1:0] line_q;

  logic               is_digit, is_lf, is_cr;
  logic [DIGIT_W-1:0] digit;
  logic               accept;
  logic               digit_wr;
  logic [CW-1:0]      cnt_inc;
  logic               term;
  logic [CW-1:0]      term_cnt;

  joltage_char_class u_class (
    .data_i     (in_data_i),
    .is_digit_o (is_digit),
    .is_lf_o    (is_lf),
    .is_cr_o    (is_cr),
    .digit_o    (digit)
  );

  assign accept   = in_valid_i && (state_q == COLLECT);
  assign cnt_inc  = (cnt_q == OVF_C) ? OVF_C : cnt_q + 1'b1;
  assign digit_wr = accept && is_digit && (cnt_q < LEN_C);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    lines_done_d = lines_done_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    finished_d   = finished_q;
    err_char_d   = err_char_q;
    err_len_d    = err_len_q;
    term         = 1'b0;
    term_cnt     = cnt_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          // Any byte flagged last closes the pending line so nothing is lost.
          if (is_digit) begin
            cnt_d    = cnt_inc;
            term_cnt = cnt_inc;
            term     = in_last_i;
          end else if (is_lf) begin
            term = 1'b1;
          end else if (is_cr) begin
            term = in_last_i;
          end else begin
            err_char_d = 1'b1;
            term       = in_last_i;
          end

          if (term) begin
            if (term_cnt == LEN_C) begin
              state_d = ISSUE;
              last_d  = in_last_i;
            end else begin
              cnt_d = '0;
              if (term_cnt != '0) err_len_d = 1'b1;
              if (in_last_i) state_d = FINISH;
            end
          end
        end
      end

      ISSUE: state_d = WAIT_BUSY;

      WAIT_BUSY: begin
        if (!done_i) state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (done_i) begin
          lines_done_d = lines_done_q + 1'b1;
          cnt_d        = '0;
          state_d      = last_q ? FINISH : COLLECT;
        end
      end

      FINISH: begin
        if (!finished_q) begin
          p1_d       = joltage1_i;
          p2_d       = joltage2_i;
          finished_d = 1'b1;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      lines_done_q <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      finished_q   <= 1'b0;
      err_char_q   <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      lines_done_q <= lines_done_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      finished_q   <= finished_d;
      err_char_q   <= err_char_d;
      err_len_q    <= err_len_d;
    end
  end

  // Digit writes only happen in COLLECT, so the line is frozen while in flight.
  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_line
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        line_q[gi] <= '0;
      end else if (digit_wr && (cnt_q == CW'(gi))) begin
        line_q[gi] <= digit;
      end
    end
  end

  assign in_ready_o   = (state_q == COLLECT);
  assign start_o      = (state_q == ISSUE);
  assign data_valid_o = (state_q == ISSUE) || (state_q == WAIT_BUSY);
  assign line_o       = line_q;
  assign p1_total_o   = p1_q;
  assign p2_total_o   = p2_q;
  assign lines_done_o = lines_done_q;
  assign finished_o   = finished_q;
  assign err_char_o   = err_char_q;
  assign err_len_o    = err_len_q;

endmodule
